// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// mult_arbiter: round-robin sharing of one multmod between NREQ sequencers.
// Revision: 1.0
// ============================================================================
module mult_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 448
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ*W-1:0] cl_x_i,
  input  logic [NREQ*W-1:0] cl_y_i,
  input  logic [NREQ-1:0]   cl_req_valid_i,
  output logic [NREQ-1:0]   cl_req_ready_o,
  output logic [NREQ-1:0]   cl_req_busy_o,
  output logic [NREQ-1:0]   cl_res_valid_o,
  input  logic [NREQ-1:0]   cl_res_ready_i,
  output logic [W-1:0]      cl_z_o,
  output logic [W-1:0]      m_x_o,
  output logic [W-1:0]      m_y_o,
  output logic              m_req_valid_o,
  input  logic              m_req_ready_i,
  input  logic              m_req_busy_i,
  input  logic              m_res_valid_i,
  output logic              m_res_ready_o,
  input  logic [W-1:0]      m_z_i
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [NREQ-1:0] req_busy_q, req_busy_d;
  logic [NREQ-1:0] res_valid_q, res_valid_d;
  logic [W-1:0]  m_x_q, m_x_d;
  logic [W-1:0]  m_y_q, m_y_d;
  logic [W-1:0]  z_q, z_d;
  logic          w_m_res_ready;

  logic [W-1:0]  w_cl_x [NREQ];
  logic [W-1:0]  w_cl_y [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_cl_x[i] = cl_x_i[i*W +: W];
    assign w_cl_y[i] = cl_y_i[i*W +: W];
  end

  // Scan upward from last+1 with wraparound; the extra bit of w_cand holds the
  // unwrapped sum so non-power-of-two NREQ wraps correctly.
  logic [IW:0]   w_cand;
  logic          w_win_found;
  logic [IW-1:0] w_win_idx;

  always_comb begin
    w_cand      = '0;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = {1'b0, last_q} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NREQ)) begin
        w_cand = w_cand - (IW+1)'(NREQ);
      end
      if (!w_win_found && cl_req_valid_i[w_cand[IW-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    req_ready_d   = '0;
    req_busy_d    = req_busy_q;
    res_valid_d   = res_valid_q;
    m_x_d         = m_x_q;
    m_y_d         = m_y_q;
    z_d           = z_q;
    w_m_res_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_win_found) begin
          m_x_d                  = w_cl_x[w_win_idx];
          m_y_d                  = w_cl_y[w_win_idx];
          req_ready_d[w_win_idx] = 1'b1;
          req_busy_d[w_win_idx]  = 1'b1;
          gnt_d                  = w_win_idx;
          state_d                = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Result handshake completes in this cycle; res_ready is a single pulse.
        if (!m_req_busy_i && m_res_valid_i) begin
          w_m_res_ready      = 1'b1;
          z_d                = m_z_i;
          req_busy_d[gnt_q]  = 1'b0;
          res_valid_d[gnt_q] = 1'b1;
          state_d            = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (cl_res_ready_i[gnt_q]) begin
          res_valid_d[gnt_q] = 1'b0;
          last_d             = gnt_q;
          state_d            = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= IW'(NREQ - 1);
      gnt_q       <= '0;
      req_ready_q <= '0;
      req_busy_q  <= '0;
      res_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      req_ready_q <= req_ready_d;
      req_busy_q  <= req_busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Operand and result registers carry data only and keep their value on reset.
  always_ff @(posedge clk) begin
    m_x_q <= m_x_d;
    m_y_q <= m_y_d;
    z_q   <= z_d;
  end

  assign cl_req_ready_o = req_ready_q;
  assign cl_req_busy_o  = req_busy_q;
  assign cl_res_valid_o = res_valid_q;
  assign cl_z_o         = z_q;
  assign m_x_o          = m_x_q;
  assign m_y_o          = m_y_q;
  assign m_req_valid_o  = (state_q == S_ISSUE);
  assign m_res_ready_o  = w_m_res_ready;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mult_arbiter: randomized bench with a multmod model and grant predictor.
// Revision: 1.0
// ============================================================================
module tb_mult_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 448;
  localparam logic [W-1:0] P448 = {W{1'b1}} - (W'(1) << 224);

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ*W-1:0] cl_x, cl_y;
  logic [NREQ-1:0]   cl_req_valid, cl_req_ready, cl_req_busy, cl_res_valid, cl_res_ready;
  logic [W-1:0]      cl_z, m_x, m_y;
  logic              m_req_valid, m_res_ready;
  logic              m_req_ready = 1'b0;
  logic              m_req_busy  = 1'b0;
  logic              m_res_valid = 1'b0;
  logic [W-1:0]      m_z = '0;

  mult_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .cl_x_i(cl_x), .cl_y_i(cl_y),
    .cl_req_valid_i(cl_req_valid), .cl_req_ready_o(cl_req_ready),
    .cl_req_busy_o(cl_req_busy), .cl_res_valid_o(cl_res_valid),
    .cl_res_ready_i(cl_res_ready), .cl_z_o(cl_z),
    .m_x_o(m_x), .m_y_o(m_y),
    .m_req_valid_o(m_req_valid), .m_req_ready_i(m_req_ready),
    .m_req_busy_i(m_req_busy), .m_res_valid_i(m_res_valid),
    .m_res_ready_o(m_res_ready), .m_z_i(m_z)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, P448};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    r = '0;
    if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 1000));
    for (int i = 0; i < W/32; i++) r = {r[W-33:0], $urandom()};
    return r % P448;
  endfunction

  function automatic bit bitof(input logic [NREQ-1:0] v, input int i);
    return 1'(v >> i);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  // Next winner: first requesting index after the last one served, mod NREQ.
  function automatic int pick(input logic [NREQ-1:0] pend, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (bitof(pend, c)) return c;
    end
    return -1;
  endfunction

  // Behavioural multmod: accept, stay busy a few cycles, hold result until taken.
  int   mm_fixed = -1;
  int   mm_cnt   = 0;
  int   mm_st    = 0;
  logic [W-1:0] mm_x, mm_y;
  logic mrr_s   = 1'b0;
  int   mrr_cnt = 0;

  always @(posedge clk) begin
    mrr_s <= m_res_ready;
    if (m_res_ready) mrr_cnt <= mrr_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      m_req_ready = 1'b0; m_req_busy = 1'b0; m_res_valid = 1'b0; mm_st = 0;
    end else begin
      case (mm_st)
        0: if (m_req_valid) begin
             mm_x = m_x; mm_y = m_y; m_req_ready = 1'b1; mm_st = 1;
           end
        1: begin
             m_req_ready = 1'b0; m_req_busy = 1'b1;
             mm_cnt = (mm_fixed >= 0) ? mm_fixed : int'($urandom_range(0, 6));
             mm_st = 2;
           end
        2: if (mm_cnt == 0) begin
             m_req_busy = 1'b0; m_res_valid = 1'b1; m_z = mulmod(mm_x, mm_y); mm_st = 3;
           end else mm_cnt--;
        3: if (mrr_s) begin
             m_res_valid = 1'b0; m_z = {W{1'b1}}; mm_st = 0;
           end
        default: mm_st = 0;
      endcase
    end
  end

  logic [W-1:0] opx [NREQ];
  logic [W-1:0] opy [NREQ];
  int model_last;

  task automatic drive(input int i);
    logic [NREQ*W-1:0] msk;
    msk  = {{(NREQ-1)*W{1'b0}}, {W{1'b1}}} << (i*W);
    cl_x = (cl_x & ~msk) | ((NREQ*W)'(opx[i]) << (i*W));
    cl_y = (cl_y & ~msk) | ((NREQ*W)'(opy[i]) << (i*W));
    cl_req_valid = cl_req_valid | onehot(i);
  endtask

  task automatic do_reset();
    cl_req_valid = '0; cl_res_ready = '0; rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; model_last = NREQ - 1;
  endtask

  task automatic run_ops(input logic [NREQ-1:0] mask, input int nops, input bit rereq, input int hold);
    logic [NREQ-1:0] pend;
    logic [W-1:0]    z_seen;
    int exp_w, w, issued, base, t;
    pend = mask;
    issued = $countones(mask);
    for (int i = 0; i < NREQ; i++) if (bitof(mask, i)) drive(i);
    @(posedge clk); #1;
    while (pend != '0) begin
      exp_w = pick(pend, model_last);
      check("grant", W'(cl_req_ready), W'(onehot(exp_w)));
      check("busy_at_grant", W'(cl_req_busy), W'(onehot(exp_w)));
      check("m_req_valid", W'(m_req_valid), W'(1));
      w = exp_w;
      for (int i = 0; i < NREQ; i++) if (cl_req_ready == onehot(i)) w = i;
      cl_req_valid = cl_req_valid & ~onehot(w);
      pend = pend & ~onehot(w);
      base = mrr_cnt;
      @(posedge clk); #1;
      check("ready_pulse", W'(cl_req_ready), '0);
      t = 0;
      while (!bitof(cl_res_valid, w) && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) begin
        check("res_timeout", W'(0), W'(1));
        do_reset();
        return;
      end
      check("z", cl_z, mulmod(opx[w], opy[w]));
      check("res_valid", W'(cl_res_valid), W'(onehot(w)));
      check("busy_cleared", W'(cl_req_busy), '0);
      z_seen = cl_z;
      cl_res_ready = ~onehot(w);
      for (int h = 0; h < hold; h++) begin @(posedge clk); #1; end
      check("z_stable", cl_z, z_seen);
      check("res_held", W'(cl_res_valid), W'(onehot(w)));
      check("held_off", W'(cl_req_ready), '0);
      cl_res_ready = onehot(w);
      @(posedge clk); #1;
      cl_res_ready = '0;
      check("res_cleared", W'(cl_res_valid), '0);
      check("no_grant_yet", W'(cl_req_ready), '0);
      check("m_res_ready_pulse", W'(mrr_cnt - base), W'(1));
      model_last = w;
      if (rereq && issued < nops) begin
        opx[w] = rand_op(); opy[w] = rand_op();
        drive(w);
        pend = pend | onehot(w);
        issued++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] m;
    rst = 1'b1; cl_req_valid = '0; cl_res_ready = '0; cl_x = '0; cl_y = '0;
    model_last = NREQ - 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", W'(cl_req_ready), '0);
    check("rst_busy", W'(cl_req_busy), '0);
    check("rst_res_valid", W'(cl_res_valid), '0);
    check("rst_m_req_valid", W'(m_req_valid), '0);
    check("rst_m_res_ready", W'(m_res_ready), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    opx[0] = W'(3); opy[0] = W'(5);
    run_ops(3'b001, 1, 1'b0, 2);
    check("single_z15", cl_z, W'(15));

    do_reset();
    opx[0] = W'(2); opy[0] = W'(7); opx[1] = W'(4); opy[1] = W'(9);
    run_ops(3'b011, 2, 1'b0, 1);
    check("simul_z36", cl_z, W'(36));

    for (int i = 0; i < NREQ; i++) begin opx[i] = rand_op(); opy[i] = rand_op(); end
    run_ops(3'b011, 6, 1'b1, 0);
    for (int i = 0; i < NREQ; i++) begin opx[i] = rand_op(); opy[i] = rand_op(); end
    run_ops(3'b111, 9, 1'b1, 0);

    opx[1] = P448 - W'(1); opy[1] = W'(2);
    run_ops(3'b010, 1, 1'b0, 0);
    check("wrap_z", cl_z, P448 - W'(2));

    for (int i = 0; i < NREQ; i++) begin opx[i] = rand_op(); opy[i] = rand_op(); end
    run_ops(3'b011, 2, 1'b0, 10);

    for (int r = 0; r < 12; r++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin opx[i] = rand_op(); opy[i] = rand_op(); end
      run_ops(m, $countones(m) + int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));
    end

    do_reset();
    mm_fixed = 30;
    opx[0] = rand_op(); opy[0] = rand_op();
    drive(0);
    @(posedge clk); #1;
    check("rw_grant", W'(cl_req_ready), W'(1));
    cl_req_valid = '0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rw_req_ready", W'(cl_req_ready), '0);
    check("rw_busy", W'(cl_req_busy), '0);
    check("rw_res_valid", W'(cl_res_valid), '0);
    check("rw_m_req_valid", W'(m_req_valid), '0);
    check("rw_m_res_ready", W'(m_res_ready), '0);
    rst = 1'b0; mm_fixed = -1; model_last = NREQ - 1;
    @(posedge clk); #1;
    opx[1] = W'(6); opy[1] = W'(6);
    run_ops(3'b010, 1, 1'b0, 0);
    check("rw_z36", cl_z, W'(36));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
